alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU. Lab control units no longer drive the ALU directly. Each one presents operands and an opcode through a req/done handshake. This block grants the ALU round-robin, drives registered operands and opcode into it, captures result and flags, and returns them to the granted requester with a one-cycle done pulse.

## Interface
Parameters:
- DATA_W, 4, ALU operand/result width
- OP_W, 4, ALU opcode width
- FLAG_W, 5, ALU flag vector width

Ports (clock and reset first):
- iClk  in  1  single clock, all logic on rising edge
- iRst_n  in  1  synchronous, active-low reset
- iReq0 / iReq1  in  1  request from requester 0 / 1, level, held until done
- iA0, iB0 / iA1, iB1  in  DATA_W  operands per requester, stable while req high
- iOp0 / iOp1  in  OP_W  opcode per requester, stable while req high
- oGnt0 / oGnt1  out  1  registered grant, high from ISSUE through RESP
- oDone0 / oDone1  out  1  one-cycle pulse, result/flags valid
- oResult  out  DATA_W  captured ALU result, held until next capture
- oFlags  out  FLAG_W  captured ALU flags, unmodified bit order, held until next capture
- oAluA, oAluB  out  DATA_W  registered operands to ALU
- oAluOp  out  OP_W  registered opcode to ALU
- iAluResult  in  DATA_W  ALU result, combinational from oAluA/oAluB/oAluOp
- iAluFlags  in  FLAG_W  ALU flags, combinational
- oCnt0 / oCnt1  out  8  completed-transaction counters (see Configuration)

## Operation
- States: IDLE, ISSUE, RESP. Encoding is free. Illegal states go to IDLE.
- IDLE, no request: stay in IDLE. oGnt*, oDone* = 0.
- IDLE, one request: grant that requester.
- IDLE, both requests: grant the requester not served last (pointer `last`).
- After reset, `last` = 1, so requester 0 wins the first tie.
- IDLE → ISSUE on grant:
  - Register the granted requester's A, B and Op into oAluA/oAluB/oAluOp.
  - Set oGntN = 1 and `last` = N.
- ISSUE → RESP:
  - Register iAluResult → oResult and iAluFlags → oFlags.
  - Set oDoneN = 1.
- RESP → IDLE: oDoneN = 0, oGntN = 0.
- oAluA/oAluB/oAluOp hold their last values in IDLE. No glitch to zero.
- Operands are sampled only at the IDLE→ISSUE edge. Changes after that edge are ignored for the current transaction.
- A requester deasserts req at the edge after it sees done high. Req still high in the next IDLE counts as a new request.
- A request that drops before grant is lost silently.
- Flags pass through untouched. Compare semantics (bit0 equal, bit2 less-than after subtract) belong to the requester.

## Timing
- Reset (iRst_n = 0 at an edge) gives:
  - state IDLE, `last` = 1
  - all outputs 0: oGnt*, oDone*, oResult, oFlags, oAluA, oAluB, oAluOp, oCnt*
- Reset mid-transaction aborts it. No done pulse and no counter increment.
- Edge k: IDLE samples req. Edge k+1: ISSUE, grant and ALU inputs valid. Edge k+2: RESP, done and result valid. Edge k+3: IDLE, next arbitration.
- Latency: 2 edges from req-sample to done-high. Throughput: 1 transaction per 3 cycles.
- Both requesters continuously requesting are served strictly alternately: 0, 1, 0, 1…
- Only one oGnt and at most one oDone are high in any cycle.

## Configuration
- Macro ALU_ARB_STATS_EN.
- Defined:
  - oCnt0/oCnt1 increment on each oDone0/oDone1 pulse, in the same edge as done rises.
  - Counters saturate at 8'hFF.
  - Counters clear only on reset.
- Undefined: the counter logic is not compiled and oCnt0/oCnt1 are tied to 8'h00. The port list is unchanged.

## Test plan
- Reset: hold iRst_n = 0 for 2 cycles with iReq0 = 1 → all outputs 0, no grant. Release → oGnt0 high after the first edge.
- Single request: iReq0 = 1, iA0 = 4'h2, iB0 = 4'h2, iOp0 = 4'h0, bench ALU subtracts → oAluA = 2, oAluB = 2 at k+1. At k+2, oDone0 = 1, oResult = 0 and oFlags bit0 = 1, with done high for exactly one cycle.
- Tie after reset: iReq0 = iReq1 = 1 held → grant order 0, 1, 0, 1. Each done arrives 3 cycles after the previous one. The oGnt signals are never high together.
- Operand hold: change iA1 from 4'h5 to 4'hA during ISSUE → oAluA stays 5 and oResult reflects 5.
- Abort: assert iRst_n = 0 in ISSUE → no oDone, and state is IDLE after release.
- Stats (ALU_ARB_STATS_EN defined): complete 300 requester-0 transactions → oCnt0 = 8'hFF and oCnt1 = 0. With the macro undefined → oCnt0 = 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU between two requesters.
// Optional per-requester completion counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 5
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic [DATA_W-1:0] iA0,
  input  logic [DATA_W-1:0] iB0,
  input  logic [OP_W-1:0]   iOp0,
  input  logic [DATA_W-1:0] iA1,
  input  logic [DATA_W-1:0] iB1,
  input  logic [OP_W-1:0]   iOp1,
  output logic              oGnt0,
  output logic              oGnt1,
  output logic              oDone0,
  output logic              oDone1,
  output logic [DATA_W-1:0] oResult,
  output logic [FLAG_W-1:0] oFlags,
  output logic [DATA_W-1:0] oAluA,
  output logic [DATA_W-1:0] oAluB,
  output logic [OP_W-1:0]   oAluOp,
  input  logic [DATA_W-1:0] iAluResult,
  input  logic [FLAG_W-1:0] iAluFlags,
  output logic [7:0]        oCnt0,
  output logic [7:0]        oCnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic last;
  logic pick1;
  logic loadOps;
  logic capture;
  logic releaseGnt;

  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = IDLE;
    case (state)
      IDLE:    stateNext = (iReq0 || iReq1) ? ISSUE : IDLE;
      ISSUE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // On a tie, requester 1 wins only if requester 0 was served last.
  always_comb begin
    loadOps    = 1'b0;
    capture    = 1'b0;
    releaseGnt = 1'b0;
    pick1      = iReq1 && (!iReq0 || !last);
    case (state)
      IDLE:    loadOps    = iReq0 || iReq1;
      ISSUE:   capture    = 1'b1;
      default: releaseGnt = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      last    <= 1'b1;
      oGnt0   <= 1'b0;
      oGnt1   <= 1'b0;
      oDone0  <= 1'b0;
      oDone1  <= 1'b0;
      oResult <= '0;
      oFlags  <= '0;
      oAluA   <= '0;
      oAluB   <= '0;
      oAluOp  <= '0;
    end else begin
      if (loadOps) begin
        oAluA  <= pick1 ? iA1  : iA0;
        oAluB  <= pick1 ? iB1  : iB0;
        oAluOp <= pick1 ? iOp1 : iOp0;
        oGnt0  <= !pick1;
        oGnt1  <= pick1;
        last   <= pick1;
      end
      if (capture) begin
        oResult <= iAluResult;
        oFlags  <= iAluFlags;
      end
      oDone0 <= capture && oGnt0;
      oDone1 <= capture && oGnt1;
      if (releaseGnt) begin
        oGnt0 <= 1'b0;
        oGnt1 <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (capture && oGnt0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (capture && oGnt1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end
  end

  assign oCnt0 = cnt0;
  assign oCnt1 = cnt1;
`else
  assign oCnt0 = '0;
  assign oCnt1 = '0;
`endif

endmodule
